// File: rtl/wb_axisin.sv
// wb_axisin: Wishbone slave that pushes words into a small FIFO drained as AXI-Stream.
// Optional macro WB_AXISIN_AUTO_TLAST_EN adds an auto-tlast length register at 0x94.
module wb_axisin #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_dat_i,
  input  logic [31:0]            wbs_adr_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_ACK
  } state_t;

  state_t                 state_q;
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic [pDATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;

  logic [7:0]  adr;
  logic        req;
  logic        is_push;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        push_last;
  logic [3:0]  cnt4;
  logic [31:0] rdata;
  logic        unused_ok;

  assign adr     = wbs_adr_i[7:0];
  assign req     = wbs_cyc_i & wbs_stb_i;
  assign is_push = wbs_we_i & ((adr == 8'h80) | (adr == 8'h88));
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign cnt4    = 4'(count_q);

  // A stalled request is retried from the held bus signals once a slot opens.
  assign push = req & is_push & ~full &
                ((state_q == S_IDLE) | (state_q == S_STALL));
  assign pop  = ~empty & ss_tready;

  assign ss_tvalid = ~empty;
  assign ss_tdata  = mem_q[rd_ptr_q][pDATA_WIDTH-1:0];
  assign ss_tlast  = mem_q[rd_ptr_q][pDATA_WIDTH];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:8], (pADDR_WIDTH > 0)};

`ifdef WB_AXISIN_AUTO_TLAST_EN
  logic [15:0] len_q;
  logic [15:0] beat_q;
  logic [15:0] beat_d;
  logic        auto_hit;
  logic        cfg_wr;

  assign auto_hit  = (len_q != '0) && ((beat_q + 16'd1) == len_q);
  assign push_last = (adr == 8'h88) | auto_hit;
  assign cfg_wr    = req & wbs_we_i & (adr == 8'h94) &
                     (state_q == S_IDLE);

  // Beat counter advances per push; clears on a marked beat or when disabled.
  always_comb begin
    beat_d = beat_q;
    if (push) begin
      beat_d = (push_last || len_q == '0) ? '0 : beat_q + 16'd1;
    end
  end

  // Length register and beat counter; a new length restarts the count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      len_q  <= '0;
      beat_q <= '0;
    end else if (cfg_wr) begin
      len_q  <= wbs_dat_i[15:0];
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  assign push_last = (adr == 8'h88);
`endif

  // Read mux; sampled into the ack register in the accepting cycle.
  always_comb begin
    rdata = '0;
    if (!wbs_we_i) begin
      unique case (adr)
        8'h8C:   rdata = {26'b0, full, empty, cnt4};
`ifdef WB_AXISIN_AUTO_TLAST_EN
        8'h94:   rdata = {16'b0, len_q};
`endif
        default: rdata = '0;
      endcase
    end
  end

  // Occupancy next state; push and pop together leave it unchanged.
  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage, deliberately left without reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_last, wbs_dat_i[pDATA_WIDTH-1:0]};
    end
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Bus FSM with registered ack and read data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if (is_push && full) begin
              state_q <= S_STALL;
            end else begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              dat_q   <= rdata;
            end
          end
        end
        S_STALL: begin
          if (!req) begin
            state_q <= S_IDLE;
          end else if (!full) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            dat_q   <= '0;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          dat_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          dat_q   <= '0;
        end
      endcase
    end
  end

endmodule
